// File: rtl/div3_serial_if.sv
// ---------------------------------------------------------------------------
// div3_serial_if : operand/result handshake bundle for div3_serial
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface div3_serial_if #(
  parameter int SIZE = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_quot;
  logic [1:0]      out_rem;
  logic            out_div;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_div
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_div
  );
endinterface

`default_nettype wire

// File: rtl/div3_serial.sv
// ---------------------------------------------------------------------------
// div3_serial : radix-4 MSB-first serial divide-by-3 (quotient, remainder, flag)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div3_serial #(
  parameter int SIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  div3_serial_if.slave     bus
);

  localparam int N  = (SIZE + 1) / 2;
  localparam int W  = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [1:0]      rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    opnd_ext;
  logic [3:0]      digit;
  logic [1:0]      q_dig;
  logic [1:0]      r_dig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;

    opnd_ext = '0;
    opnd_ext[SIZE-1:0] = bus.in_data;

    // d = 4r + b is at most 11 since r never exceeds 2
    digit = {rem_q, opnd_q[W-1 -: 2]};
    if (digit >= 4'd9) begin
      q_dig = 2'd3;
      r_dig = 2'(digit - 4'd9);
    end else if (digit >= 4'd6) begin
      q_dig = 2'd2;
      r_dig = 2'(digit - 4'd6);
    end else if (digit >= 4'd3) begin
      q_dig = 2'd1;
      r_dig = 2'(digit - 4'd3);
    end else begin
      q_dig = 2'd0;
      r_dig = digit[1:0];
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = BUSY;
          opnd_d  = opnd_ext;
          quot_d  = '0;
          rem_d   = '0;
          cnt_d   = CW'(N - 1);
        end
      end
      BUSY: begin
        opnd_d = opnd_q << 2;
        quot_d = W'({quot_q, q_dig});
        rem_d  = r_dig;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  // Top quotient bit is always zero for odd SIZE, so truncation loses nothing
  assign bus.out_quot  = SIZE'(quot_q);
  assign bus.out_rem   = rem_q;
  assign bus.out_div   = (state_q == DONE) && (rem_q == 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_div3_serial.sv
// ---------------------------------------------------------------------------
// tb_div3_serial : directed and random checks of div3_serial at SIZE 32, 5, 7
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div3_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [2:0]  vld;
  logic [2:0]  rdy;

  logic [2:0]  ov;
  logic [2:0]  ir;
  logic [2:0]  od;
  logic [31:0] oq [3];
  logic [1:0]  orm [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div3_serial_if #(.SIZE(32)) if32 ();
  div3_serial_if #(.SIZE(5))  if5  ();
  div3_serial_if #(.SIZE(7))  if7  ();

  div3_serial #(.SIZE(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
  div3_serial #(.SIZE(5))  u5  (.clk(clk), .rst(rst), .bus(if5));
  div3_serial #(.SIZE(7))  u7  (.clk(clk), .rst(rst), .bus(if7));

  assign if32.in_valid  = vld[0];
  assign if32.in_data   = din;
  assign if32.out_ready = rdy[0];
  assign if5.in_valid   = vld[1];
  assign if5.in_data    = din[4:0];
  assign if5.out_ready  = rdy[1];
  assign if7.in_valid   = vld[2];
  assign if7.in_data    = din[6:0];
  assign if7.out_ready  = rdy[2];

  assign ov     = {if7.out_valid, if5.out_valid, if32.out_valid};
  assign ir     = {if7.in_ready,  if5.in_ready,  if32.in_ready};
  assign od     = {if7.out_div,   if5.out_div,   if32.out_div};
  assign oq[0]  = if32.out_quot;
  assign oq[1]  = {27'd0, if5.out_quot};
  assign oq[2]  = {25'd0, if7.out_quot};
  assign orm[0] = if32.out_rem;
  assign orm[1] = if5.out_rem;
  assign orm[2] = if7.out_rem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int size);
    logic [32:0] one;
    one = 33'd1 << size;
    return 32'(one - 33'd1);
  endfunction

  // Offer one operand to an idle unit, check latency and result, optionally complete the handshake
  task automatic do_op(input int sel, input logic [31:0] a, input int size,
                       input int n, input string tag, input bit release_it);
    logic [31:0] ea;
    int lat;
    ea = a & mask_of(size);
    @(negedge clk);
    din = a; vld[sel] = 1'b1; rdy[sel] = 1'b0;
    @(posedge clk); #1;
    vld[sel] = 1'b0;
    chk({tag, "_busy_ready"}, 32'(ir[sel]), 32'd0);
    lat = 0;
    while (!ov[sel] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, n);
    chk({tag, "_quot"}, oq[sel], ea / 3);
    chk({tag, "_rem"}, 32'(orm[sel]), ea % 3);
    chk({tag, "_div"}, 32'(od[sel]), ((ea % 3) == 0) ? 32'd1 : 32'd0);
    if (release_it) begin
      @(negedge clk); rdy[sel] = 1'b1;
      @(posedge clk); #1;
      rdy[sel] = 1'b0;
      chk({tag, "_idle_ready"}, 32'(ir[sel]), 32'd1);
      chk({tag, "_idle_valid"}, 32'(ov[sel]), 32'd0);
    end
  endtask

  // Back-to-back random operands with random backpressure, scoreboarded in order
  task automatic run_rand(input int sel, input int size, input int nops, input int budget, input string tag);
    logic [31:0] sb [$];
    logic [31:0] a;
    int sent, got, cyc;
    bit need_new;
    sent = 0; got = 0; cyc = 0; need_new = 1'b1;
    while (got < nops && cyc < budget) begin
      @(negedge clk);
      if (need_new) begin
        din = $urandom;
        need_new = 1'b0;
      end
      vld[sel] = (sent < nops);
      rdy[sel] = 1'($urandom_range(0, 1));
      if (ov[sel] && rdy[sel]) begin
        if (sb.size() == 0) begin
          chk({tag, "_unexpected_result"}, 32'd1, 32'd0);
        end else begin
          a = sb.pop_front();
          chk({tag, "_quot"}, oq[sel], a / 3);
          chk({tag, "_rem"}, 32'(orm[sel]), a % 3);
          chk({tag, "_div"}, 32'(od[sel]), ((a % 3) == 0) ? 32'd1 : 32'd0);
        end
        got++;
      end
      if (vld[sel] && ir[sel]) begin
        sb.push_back(din & mask_of(size));
        sent++;
        need_new = 1'b1;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    vld[sel] = 1'b0; rdy[sel] = 1'b0;
    chk({tag, "_results_seen"}, got, nops);
    chk({tag, "_leftover"}, sb.size(), 0);
  endtask

  initial begin : main
    int seen;
    logic [31:0] hq;
    logic [1:0]  hr;
    rst = 1'b1; din = '0; vld = '0; rdy = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset_in_ready", 32'(ir[s]), 32'd1);
      chk("reset_out_valid", 32'(ov[s]), 32'd0);
      chk("reset_quot", oq[s], 32'd0);
      chk("reset_rem", 32'(orm[s]), 32'd0);
      chk("reset_div", 32'(od[s]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    do_op(0, 32'd100,        32, 16, "op100",  1'b1);
    do_op(0, 32'hFFFFFFFF,   32, 16, "ones",   1'b1);
    do_op(0, 32'hFFFFFFFE,   32, 16, "onesm1", 1'b1);
    do_op(0, 32'd0,          32, 16, "zero",   1'b1);

    // Backpressure: result held while a fresh operand is offered and ignored
    do_op(0, 32'd100, 32, 16, "bp", 1'b0);
    hq = oq[0]; hr = orm[0];
    @(negedge clk); din = 32'd55; vld[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(ov[0]), 32'd1);
      chk("bp_in_ready", 32'(ir[0]), 32'd0);
      chk("bp_quot_stable", oq[0], hq);
      chk("bp_rem_stable", 32'(orm[0]), 32'(hr));
    end
    @(negedge clk); vld[0] = 1'b0; rdy[0] = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b0;
    chk("bp_release_ready", 32'(ir[0]), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_consume", 32'(ir[0]), 32'd1);

    // Reset mid-operation, with in_valid asserted in the reset cycle
    @(negedge clk); din = 32'd12345; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1; vld[0] = 1'b1; din = 32'd777;
    @(posedge clk); #1;
    chk("rst_mid_ready", 32'(ir[0]), 32'd1);
    chk("rst_mid_valid", 32'(ov[0]), 32'd0);
    @(negedge clk); rst = 1'b0; vld[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_vld_not_taken", 32'(ir[0]), 32'd1);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ov[0]) seen++;
    end
    chk("rst_no_result", seen, 0);
    do_op(0, 32'd9, 32, 16, "after_rst", 1'b1);

    do_op(1, 32'd31, 5, 3, "s5_31", 1'b1);
    do_op(1, 32'd30, 5, 3, "s5_30", 1'b1);
    do_op(2, 32'd127, 7, 4, "s7_ones", 1'b1);

    run_rand(0, 32, 1000, 45000, "rand32");
    run_rand(2, 7,  1500, 20000, "rand7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
